// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len words out of a FIFO and presents them one at a
// time on a valid/ready stream, aborting with err if the FIFO stays empty too long.
module fifo_reader #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        burst_len,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        words_sent
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] len;
   logic [7:0] empty_cnt;
   logic [8:0] empty_cnt_inc;
   logic       timeout_hit;
   logic       last_word;

   assign empty_cnt_inc = {1'b0, empty_cnt} + 9'd1;
   assign timeout_hit   = (empty_cnt_inc >= 9'(TIMEOUT));
   assign last_word     = ((words_sent + 4'd1) == len);

   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fifo_rd   = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = REQ;
         REQ: begin
            if (!fifo_empty) begin
               fifo_rd   = 1'b1;
               state_nxt = WAIT;
            end else if (timeout_hit) begin
               state_nxt = DONE;
            end
         end
         WAIT: state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = last_word ? DONE : REQ;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst bookkeeping; a zero or oversized length is treated as a full 8-word burst.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len        <= 4'd0;
         empty_cnt  <= 8'd0;
         out_data   <= '0;
         words_sent <= 4'd0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len        <= (burst_len == 4'd0 || burst_len > 4'd8) ? 4'd8 : burst_len;
                  words_sent <= 4'd0;
                  err        <= 1'b0;
                  empty_cnt  <= 8'd0;
               end
            end
            REQ: begin
               if (!fifo_empty) begin
                  empty_cnt <= 8'd0;
               end else begin
                  if (empty_cnt != 8'hFF) empty_cnt <= empty_cnt_inc[7:0];
                  if (timeout_hit) err <= 1'b1;
               end
            end
            WAIT: out_data <= fifo_data;
            HOLD: if (out_ready) words_sent <= words_sent + 4'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a small behavioural FIFO feeding the DUT.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  burst_len;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        fifo_rd;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  words_sent;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   int          rd_cnt, rd_first, rd_last, gap_bad, valid_first, done_cyc;
   logic [31:0] got [$];

   fifo_reader #(.DATA_W(32), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .burst_len  (burst_len),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   // Read data appears the cycle after the strobe, like a synchronous FIFO.
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd && !fifo_empty) begin
         fifo_data <= mem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr[5:0]] = base + 32'(i);
         wr_ptr++;
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      return (got.size() > i) ? got[i] : 32'hDEAD_BEEF;
   endfunction

   // Cycle 1 is the cycle right after the edge that samples start.
   task automatic run_burst(input logic [3:0] bl, input int max_cyc);
      got.delete();
      rd_cnt = 0; rd_first = -1; rd_last = -100; gap_bad = 0;
      valid_first = -1; done_cyc = -1;
      burst_len = bl;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= max_cyc; k++) begin
         if (fifo_rd) begin
            if (rd_first < 0) rd_first = k;
            else if (k - rd_last != 3) gap_bad++;
            rd_last = k;
            rd_cnt++;
         end
         if (out_valid && valid_first < 0) valid_first = k;
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) begin
            done_cyc = k;
            break;
         end
         step();
      end
      check("burst_finished", {31'd0, done_cyc >= 0}, 32'd1);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; burst_len = 4'd0; out_ready = 1'b1;
      step(); step();
      check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_words", {28'd0, words_sent}, 32'd0);
      reset = 1'b1;
      step();

      // Four-word burst, ready always high
      load(32'hA0, 4);
      run_burst(4'd4, 40);
      check("b4_rd_cnt", 32'(rd_cnt), 32'd4);
      check("b4_rd_first", 32'(rd_first), 32'd1);
      check("b4_rd_gap", 32'(gap_bad), 32'd0);
      check("b4_valid_first", 32'(valid_first), 32'd3);
      check("b4_done_cyc", 32'(done_cyc), 32'd13);
      for (int i = 0; i < 4; i++) check("b4_data", word_at(i), 32'hA0 + 32'(i));
      check("b4_words", {28'd0, words_sent}, 32'd4);
      check("b4_err", {31'd0, err}, 32'd0);
      check("b4_busy_in_done", {31'd0, busy}, 32'd1);
      step();
      check("b4_done_one_cycle", {31'd0, done}, 32'd0);
      check("b4_idle_busy", {31'd0, busy}, 32'd0);
      check("b4_words_held", {28'd0, words_sent}, 32'd4);

      // Length 0 clamps to 8
      load(32'hB0, 8);
      run_burst(4'd0, 60);
      check("b0_count", 32'(got.size()), 32'd8);
      check("b0_rd_cnt", 32'(rd_cnt), 32'd8);
      check("b0_last", word_at(7), 32'hB7);
      check("b0_words", {28'd0, words_sent}, 32'd8);
      check("b0_done_cyc", 32'(done_cyc), 32'd25);
      step();

      // Length 9 clamps to 8
      load(32'hC0, 8);
      run_burst(4'd9, 60);
      check("b9_count", 32'(got.size()), 32'd8);
      check("b9_words", {28'd0, words_sent}, 32'd8);
      check("b9_done_cyc", 32'(done_cyc), 32'd25);
      check("b9_fifo_drained", {31'd0, fifo_empty}, 32'd1);
      step();

      // Timeout: three requested, only one available
      load(32'hD0, 1);
      run_burst(4'd3, 60);
      check("to_count", 32'(got.size()), 32'd1);
      check("to_data", word_at(0), 32'hD0);
      check("to_done_cyc", 32'(done_cyc), 32'd20);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_words", {28'd0, words_sent}, 32'd1);
      step();
      check("to_err_held", {31'd0, err}, 32'd1);
      check("to_idle_busy", {31'd0, busy}, 32'd0);

      // Backpressure in HOLD with a spare word left in the FIFO
      load(32'hE0, 2);
      out_ready = 1'b0;
      burst_len = 4'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("bp_err_cleared", {31'd0, err}, 32'd0);
      check("bp_rd", {31'd0, fifo_rd}, 32'd1);
      step(); step();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_data", out_data, 32'hE0);
         check("bp_no_rd", {31'd0, fifo_rd}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      check("bp_valid_release", {31'd0, out_valid}, 32'd1);
      step();
      check("bp_done", {31'd0, done}, 32'd1);
      check("bp_words", {28'd0, words_sent}, 32'd1);
      step();
      check("bp_idle_busy", {31'd0, busy}, 32'd0);
      check("bp_idle_rd", {31'd0, fifo_rd}, 32'd0);
      wr_ptr = rd_ptr;

      // Reset mid-HOLD, with an ignored start in WAIT
      load(32'hF0, 1);
      out_ready = 1'b0;
      burst_len = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("rh_valid", {31'd0, out_valid}, 32'd1);
      check("rh_busy", {31'd0, busy}, 32'd1);
      check("rh_data", out_data, 32'hF0);
      #2 reset = 1'b0;
      #1;
      check("rh_valid_drop", {31'd0, out_valid}, 32'd0);
      check("rh_busy_drop", {31'd0, busy}, 32'd0);
      check("rh_words", {28'd0, words_sent}, 32'd0);
      check("rh_data_clr", out_data, 32'd0);
      step();
      check("rh_no_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      step();
      check("rh_idle", {31'd0, busy}, 32'd0);

      out_ready = 1'b1;
      load(32'h5A, 1);
      run_burst(4'd1, 20);
      check("ar_done_cyc", 32'(done_cyc), 32'd4);
      check("ar_data", word_at(0), 32'h5A);
      check("ar_words", {28'd0, words_sent}, 32'd1);
      check("ar_err", {31'd0, err}, 32'd0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
